// File: rtl/note_sequencer_if.sv
// Host-side bundle for the note sequencer: table write port, transport
// controls and playback status.
interface note_sequencer_if #(
  parameter int unsigned SLOTS = 16
);
  localparam int unsigned AW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_half_period;
  logic [11:0]   wr_duration;
  logic          start;
  logic          stop;
  logic          loop_en;
  logic          toneOut;
  logic          busy;
  logic [AW-1:0] note_index;
  logic          done;

  modport master (
    output wr_en, wr_addr, wr_half_period, wr_duration, start, stop, loop_en,
    input  toneOut, busy, note_index, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_half_period, wr_duration, start, stop, loop_en,
    output toneOut, busy, note_index, done
  );
endinterface

// File: rtl/note_sequencer.sv
// Note sequencer: plays a table of (half-period, duration) entries as a square
// wave, one slot after another, with optional looping and stop/abort.
module note_sequencer #(
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned SLOTS    = 16
) (
  input  logic             inputClock,
  input  logic             reset,
  note_sequencer_if.slave  bus
);

  localparam int unsigned AW      = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [15:0] PreLast = 16'(TICK_DIV - 1);
  localparam logic [AW-1:0] LastIdx = AW'(SLOTS - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StPlay, StNext} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [15:0]   half_q, half_d;
  logic [15:0]   tcnt_q, tcnt_d;
  logic          tone_q, tone_d;
  logic [15:0]   pre_q, pre_d;
  logic [11:0]   dur_q, dur_d;
  logic          played_q, played_d;
  logic          done_q, done_d;
  logic          end_hit;

  // Note table; contents survive reset by design.
  logic [15:0] half_mem [SLOTS];
  logic [11:0] dur_mem  [SLOTS];
  logic [15:0] rd_half;
  logic [11:0] rd_dur;

  // Table write port, open in every state.
  always_ff @(posedge inputClock) begin
    if (bus.wr_en) begin
      half_mem[bus.wr_addr] <= bus.wr_half_period;
      dur_mem[bus.wr_addr]  <= bus.wr_duration;
    end
  end

  // Asynchronous read: a same-cycle write lands at the edge, so LOAD sees old data.
  assign rd_half = half_mem[idx_q];
  assign rd_dur  = dur_mem[idx_q];

  // State and datapath registers.
  always_ff @(posedge inputClock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      half_q   <= '0;
      tcnt_q   <= '0;
      tone_q   <= 1'b0;
      pre_q    <= '0;
      dur_q    <= '0;
      played_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      half_q   <= half_d;
      tcnt_q   <= tcnt_d;
      tone_q   <= tone_d;
      pre_q    <= pre_d;
      dur_q    <= dur_d;
      played_q <= played_d;
      done_q   <= done_d;
    end
  end

  // Next-state and counter update logic.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    half_d   = half_q;
    tcnt_d   = tcnt_q;
    tone_d   = tone_q;
    pre_d    = pre_q;
    dur_d    = dur_q;
    played_d = played_q;
    done_d   = 1'b0;
    end_hit  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start && !bus.stop) begin
          state_d  = StLoad;
          idx_d    = '0;
          played_d = 1'b0;
        end
      end
      StLoad: begin
        if (rd_dur == 12'd0) begin
          end_hit = 1'b1;
        end else begin
          state_d  = StPlay;
          half_d   = rd_half;
          dur_d    = rd_dur;
          pre_d    = '0;
          tcnt_d   = '0;
          tone_d   = 1'b0;
          played_d = 1'b1;
        end
      end
      StPlay: begin
        // Rest (half_q == 0) leaves tone_q at its loaded 0.
        if (half_q != 16'd0) begin
          if (tcnt_q == half_q - 16'd1) begin
            tcnt_d = '0;
            tone_d = ~tone_q;
          end else begin
            tcnt_d = tcnt_q + 16'd1;
          end
        end
        if (pre_q == PreLast) begin
          pre_d = '0;
          dur_d = dur_q - 12'd1;
          if (dur_q == 12'd1) begin
            state_d = StNext;
          end
        end else begin
          pre_d = pre_q + 16'd1;
        end
      end
      StNext: begin
        tone_d = 1'b0;
        if (idx_q == LastIdx) begin
          end_hit = 1'b1;
        end else begin
          idx_d   = idx_q + AW'(1);
          state_d = StLoad;
        end
      end
      default: state_d = StIdle;
    endcase

    // Looping needs at least one real note, so an empty table cannot spin.
    if (end_hit) begin
      idx_d = '0;
      if (bus.loop_en && played_q) begin
        state_d = StLoad;
      end else begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
    end

    // Abort overrides everything, including a simultaneous start.
    if (bus.stop && (state_q != StIdle)) begin
      state_d = StIdle;
      idx_d   = '0;
      tone_d  = 1'b0;
      done_d  = 1'b1;
    end
  end

  // Outputs; tone is gated by PLAY so reset or leaving PLAY silences it at once.
  always_comb begin
    bus.toneOut    = tone_q & (state_q == StPlay);
    // busy stays up through the done cycle so the host sees it fall with done.
    bus.busy       = (state_q != StIdle) | done_q;
    bus.note_index = idx_q;
    bus.done       = done_q;
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed testbench for note_sequencer with TICK_DIV=4, SLOTS=4.
module tb_note_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  note_sequencer_if #(.SLOTS(4)) bus ();

  note_sequencer #(
    .TICK_DIV(4),
    .SLOTS   (4)
  ) dut (
    .inputClock(clk),
    .reset     (rst),
    .bus       (bus)
  );

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic write_slot(input int a, input int h, input int d);
    bus.wr_en          = 1'b1;
    bus.wr_addr        = 2'(a);
    bus.wr_half_period = 16'(h);
    bus.wr_duration    = 12'(d);
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic load_table_a();
    write_slot(0, 3, 2);
    write_slot(1, 0, 1);
    write_slot(2, 0, 0);
  endtask

  // Leaves the bench at the LOAD cycle of slot 0 (t=1).
  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_timeout: busy=%b after %0d cycles, want 0", name, bus.busy, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    steps(2);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.toneOut !== 1'b0 ||
        bus.note_index !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b tone=%b idx=%0d want 0 0 0 0",
               bus.busy, bus.done, bus.toneOut, bus.note_index);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int exp_tone [19] = '{0,0,0,0,1,1,1,0,0,0, 0,0,0,0,0,0,0,0,0};
    int exp_idx  [19] = '{0,0,0,0,0,0,0,0,0,0, 1,1,1,1,1,1,2,0,0};
    int exp_busy [19] = '{1,1,1,1,1,1,1,1,1,1, 1,1,1,1,1,1,1,1,0};
    int exp_done [19] = '{0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,1,0};
    load_table_a();
    pulse_start();
    for (int t = 0; t < 19; t++) begin
      if (t > 0) step();
      checks++;
      if (bus.toneOut !== 1'(exp_tone[t])) begin
        errors++;
        $display("FAIL basic_tone t=%0d: got %b want %0d", t + 1, bus.toneOut, exp_tone[t]);
      end
      checks++;
      if (bus.note_index !== 2'(exp_idx[t])) begin
        errors++;
        $display("FAIL basic_idx t=%0d: got %0d want %0d", t + 1, bus.note_index, exp_idx[t]);
      end
      checks++;
      if (bus.busy !== 1'(exp_busy[t])) begin
        errors++;
        $display("FAIL basic_busy t=%0d: got %b want %0d", t + 1, bus.busy, exp_busy[t]);
      end
      checks++;
      if (bus.done !== 1'(exp_done[t])) begin
        errors++;
        $display("FAIL basic_done t=%0d: got %b want %0d", t + 1, bus.done, exp_done[t]);
      end
    end
  endtask

  task automatic test_end_marker_slot0();
    int nbusy = 0;
    int ndone = 0;
    int ntone = 0;
    write_slot(0, 5, 0);
    pulse_start();
    for (int t = 0; t < 8; t++) begin
      if (t > 0) step();
      nbusy += int'(bus.busy);
      ndone += int'(bus.done);
      ntone += int'(bus.toneOut);
    end
    checks++;
    if (nbusy != 2) begin
      errors++;
      $display("FAIL marker0_busy_cycles: got %0d want 2", nbusy);
    end
    checks++;
    if (ndone != 1) begin
      errors++;
      $display("FAIL marker0_done_pulses: got %0d want 1", ndone);
    end
    checks++;
    if (ntone != 0) begin
      errors++;
      $display("FAIL marker0_tone_high: got %0d cycles want 0", ntone);
    end
  endtask

  task automatic test_loop();
    int ndone = 0;
    load_table_a();
    bus.loop_en = 1'b1;
    pulse_start();
    for (int t = 1; t <= 30; t++) begin
      if (t > 1) step();
      ndone += int'(bus.done);
      if (t == 5 || t == 18) begin
        checks++;
        if (bus.note_index !== 2'd0) begin
          errors++;
          $display("FAIL loop_idx0 t=%0d: got %0d want 0", t, bus.note_index);
        end
      end
      if (t == 13 || t == 28) begin
        checks++;
        if (bus.note_index !== 2'd1) begin
          errors++;
          $display("FAIL loop_idx1 t=%0d: got %0d want 1", t, bus.note_index);
        end
      end
      if (t == 23) begin
        checks++;
        if (bus.toneOut !== 1'b1) begin
          errors++;
          $display("FAIL loop_replay_tone t=23: got %b want 1", bus.toneOut);
        end
      end
    end
    checks++;
    if (ndone != 0) begin
      errors++;
      $display("FAIL loop_no_done: got %0d pulses want 0", ndone);
    end
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    checks++;
    if (bus.done !== 1'b1 || bus.note_index !== 2'd0 || bus.toneOut !== 1'b0) begin
      errors++;
      $display("FAIL loop_stop: done=%b idx=%0d tone=%b want 1 0 0",
               bus.done, bus.note_index, bus.toneOut);
    end
    step();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL loop_stop_idle: busy=%b done=%b want 0 0", bus.busy, bus.done);
    end
    bus.loop_en = 1'b0;
  endtask

  task automatic test_all_slots();
    int ndone = 0;
    for (int s = 0; s < 4; s++) write_slot(s, 1, 1);
    pulse_start();
    for (int t = 1; t <= 26; t++) begin
      if (t > 1) step();
      if (t < 25) ndone += int'(bus.done);
      if (t >= 2 && t <= 5) begin
        checks++;
        if (bus.toneOut !== 1'(t % 2 == 1)) begin
          errors++;
          $display("FAIL all_tone t=%0d: got %b want %0d", t, bus.toneOut, t % 2);
        end
      end
      if (t == 19 || t == 24) begin
        checks++;
        if (bus.note_index !== 2'd3) begin
          errors++;
          $display("FAIL all_idx3 t=%0d: got %0d want 3", t, bus.note_index);
        end
      end
      if (t == 25) begin
        checks++;
        if (bus.done !== 1'b1 || bus.note_index !== 2'd0) begin
          errors++;
          $display("FAIL all_end: done=%b idx=%0d want 1 0", bus.done, bus.note_index);
        end
      end
      if (t == 26) begin
        checks++;
        if (bus.busy !== 1'b0) begin
          errors++;
          $display("FAIL all_busy_fall: got %b want 0", bus.busy);
        end
      end
    end
    checks++;
    if (ndone != 0) begin
      errors++;
      $display("FAIL all_early_done: got %0d pulses want 0", ndone);
    end
  endtask

  task automatic test_reset_mid_play();
    load_table_a();
    pulse_start();
    steps(4);
    checks++;
    if (bus.toneOut !== 1'b1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL rstplay_pre: tone=%b busy=%b want 1 1", bus.toneOut, bus.busy);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.toneOut !== 1'b0 || bus.busy !== 1'b0 || bus.note_index !== 2'd0) begin
      errors++;
      $display("FAIL rstplay_async: tone=%b busy=%b idx=%0d want 0 0 0",
               bus.toneOut, bus.busy, bus.note_index);
    end
    step();
    rst = 1'b0;
    step();
    pulse_start();
    checks++;
    if (bus.note_index !== 2'd0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL rstplay_restart: idx=%0d busy=%b want 0 1", bus.note_index, bus.busy);
    end
    steps(3);
    checks++;
    if (bus.toneOut !== 1'b0) begin
      errors++;
      $display("FAIL rstplay_t4: tone=%b want 0", bus.toneOut);
    end
    step();
    checks++;
    if (bus.toneOut !== 1'b1) begin
      errors++;
      $display("FAIL rstplay_t5: tone=%b want 1", bus.toneOut);
    end
    wait_idle("rstplay");
  endtask

  task automatic test_start_stop();
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_stop: done=%b busy=%b want 0 0", bus.done, bus.busy);
    end
    bus.stop  = 1'b1;
    bus.start = 1'b1;
    step();
    bus.stop  = 1'b0;
    bus.start = 1'b0;
    step();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_start_stop: done=%b busy=%b want 0 0", bus.done, bus.busy);
    end
    pulse_start();
    steps(2);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    checks++;
    if (bus.note_index !== 2'd0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_start_t4: idx=%0d busy=%b want 0 1", bus.note_index, bus.busy);
    end
    step();
    checks++;
    if (bus.toneOut !== 1'b1) begin
      errors++;
      $display("FAIL busy_start_no_restart: tone=%b want 1", bus.toneOut);
    end
    steps(6);
    checks++;
    if (bus.note_index !== 2'd1) begin
      errors++;
      $display("FAIL busy_start_continue: idx=%0d want 1", bus.note_index);
    end
    steps(2);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    step();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    checks++;
    if (bus.done !== 1'b1 || bus.note_index !== 2'd0 || bus.toneOut !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_stop: done=%b idx=%0d tone=%b want 1 0 0",
               bus.done, bus.note_index, bus.toneOut);
    end
    step();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_stop_idle: busy=%b want 0", bus.busy);
    end
  endtask

  task automatic test_same_cycle_write();
    pulse_start();
    steps(10);
    checks++;
    if (bus.note_index !== 2'd1) begin
      errors++;
      $display("FAIL wrload_at_load: idx=%0d want 1", bus.note_index);
    end
    // Rewrite slot 1 during its own LOAD cycle.
    write_slot(1, 1, 1);
    step();
    checks++;
    if (bus.toneOut !== 1'b0) begin
      errors++;
      $display("FAIL wrload_old_data: tone=%b want 0", bus.toneOut);
    end
    wait_idle("wrload");
    step();
    pulse_start();
    steps(12);
    checks++;
    if (bus.toneOut !== 1'b1) begin
      errors++;
      $display("FAIL wrload_new_data: tone=%b want 1", bus.toneOut);
    end
    wait_idle("wrload2");
  endtask

  initial begin
    rst                = 1'b1;
    bus.wr_en          = 1'b0;
    bus.wr_addr        = '0;
    bus.wr_half_period = '0;
    bus.wr_duration    = '0;
    bus.start          = 1'b0;
    bus.stop           = 1'b0;
    bus.loop_en        = 1'b0;
    test_reset();
    test_basic();
    step();
    test_end_marker_slot0();
    test_loop();
    step();
    test_all_slots();
    step();
    test_reset_mid_play();
    step();
    test_start_stop();
    step();
    test_same_cycle_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
